sm_display_scan: RTL



---
 rtl/sm_display_scan.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sm_display_scan.sv
// Three-digit multiplexed 7-segment scanner for a sign-magnitude result (-15..+15).
// New results are staged in a pending register and become visible only at a frame boundary.
module sm_display_scan #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       LOAD,
   input  logic       SGN,
   input  logic [3:0] MAG,
   input  logic       BLANK,
   output logic [2:0] AN,
   output logic [6:0] SEG,
   output logic       FRAME
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      S_UNITS = 2'd0,
      S_TENS  = 2'd1,
      S_SIGN  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_sgn_q, pend_sgn_d;
   logic [3:0]       pend_mag_q, pend_mag_d;
   logic             shown_sgn_q, shown_sgn_d;
   logic [3:0]       shown_mag_q, shown_mag_d;
   logic             frame_q, frame_d;
   logic             tick_c;
   logic             boundary_c;
   logic             tens_c;
   logic [3:0]       units_c;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = SEG_BLANK;
      endcase
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_UNITS;
         cnt_q       <= '0;
         pend_sgn_q  <= 1'b0;
         pend_mag_q  <= 4'd0;
         shown_sgn_q <= 1'b0;
         shown_mag_q <= 4'd0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_sgn_q  <= pend_sgn_d;
         pend_mag_q  <= pend_mag_d;
         shown_sgn_q <= shown_sgn_d;
         shown_mag_q <= shown_mag_d;
         frame_q     <= frame_d;
      end
   end

   // Next-state: prescaler, scan rotation, pending/shown staging
   always_comb begin
      tick_c      = (cnt_q == CNT_MAX);
      boundary_c  = tick_c && (state_q == S_SIGN);
      cnt_d       = tick_c ? '0 : cnt_q + CNT_W'(1);
      state_d     = state_q;
      pend_sgn_d  = pend_sgn_q;
      pend_mag_d  = pend_mag_q;
      shown_sgn_d = shown_sgn_q;
      shown_mag_d = shown_mag_q;
      frame_d     = boundary_c;

      if (tick_c) begin
         case (state_q)
            S_UNITS: state_d = S_TENS;
            S_TENS:  state_d = S_SIGN;
            default: state_d = S_UNITS;
         endcase
      end
      // shown takes the old pending value even when LOAD coincides with the boundary
      if (boundary_c) begin
         shown_sgn_d = pend_sgn_q;
         shown_mag_d = pend_mag_q;
      end
      if (LOAD) begin
         pend_sgn_d = SGN;
         pend_mag_d = MAG;
      end
   end

   // Output decode from registered state and shown value
   always_comb begin
      tens_c  = (shown_mag_q >= 4'd10);
      units_c = tens_c ? shown_mag_q - 4'd10 : shown_mag_q;
      AN      = 3'b111;
      SEG     = SEG_BLANK;
      case (state_q)
         S_UNITS: begin
            AN  = 3'b110;
            SEG = glyph(units_c);
         end
         S_TENS: begin
            AN  = 3'b101;
            SEG = tens_c ? glyph(4'd1) : SEG_BLANK;
         end
         S_SIGN: begin
            AN  = 3'b011;
            SEG = (shown_sgn_q && (shown_mag_q != 4'd0)) ? SEG_DASH : SEG_BLANK;
         end
         default: begin
            AN  = 3'b111;
            SEG = SEG_BLANK;
         end
      endcase
      if (BLANK) AN = 3'b111;
   end

   assign FRAME = frame_q;

endmodule
